// File: rtl/tick_stopwatch.sv
// Two-digit BCD stopwatch counting rising edges of a divided tick; IDLE/RUN/PAUSE control.
// Optional lap-freeze display hold compiled in with `define STOPWATCH_LAP_EN.
module tick_stopwatch #(
  parameter int unsigned TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] digits,
  output logic [1:0] run_state,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       wrap_q, wrap_d;
  logic       tick_prev_q;
  logic       tick_ev_c;

  assign tick_ev_c = tick_in & ~tick_prev_q;

  // State, count and wrap registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      wrap_q      <= 1'b0;
      tick_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      wrap_q      <= wrap_d;
      tick_prev_q <= tick_in;
    end
  end

  // Next-state and BCD count; clear overrides run control and a coincident event
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    wrap_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE:    if (start_stop) state_d = RUN;
        RUN:     if (start_stop) state_d = PAUSE;
        PAUSE:   if (start_stop) state_d = RUN;
        default: state_d = IDLE;
      endcase
      if (state_q == RUN && tick_ev_c) begin
        if (ones_q >= 4'd9) begin
          ones_d = 4'd0;
          if (tens_q >= 4'(TENS_MAX)) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
  end

  assign run_state = state_q;
  assign wrap      = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic       freeze_q, freeze_d;
  logic [7:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freeze_q <= 1'b0;
      hold_q   <= 8'h00;
    end else begin
      freeze_q <= freeze_d;
      hold_q   <= hold_d;
    end
  end

  // Lap toggles the freeze; entering freeze captures the count shown at that moment
  always_comb begin
    freeze_d = freeze_q;
    hold_d   = hold_q;
    if (clear) begin
      freeze_d = 1'b0;
    end else if (lap && state_q != IDLE) begin
      freeze_d = ~freeze_q;
      if (!freeze_q) hold_d = {tens_q, ones_q};
    end
  end

  assign digits = freeze_q ? hold_q : {tens_q, ones_q};
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign digits     = {tens_q, ones_q};
`endif

endmodule

// File: doc/tick_stopwatch.md
TICK_STOPWATCH -- requirements
Module: tick_stopwatch

Interface
REQ-001 SHALL have parameter TENS_MAX, default 5, meaning the last tens digit before wrap (count range 00..TENS_MAX9); legal range 1..9.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick_in  input  1  divided-clock square wave, synchronous to clk (the toggling output of the modulo divider stage).
REQ-005 SHALL have port start_stop  input  1  single-cycle run/pause request.
REQ-006 SHALL have port clear  input  1  single-cycle clear request.
REQ-007 SHALL have port lap  input  1  single-cycle lap-freeze toggle; used only when STOPWATCH_LAP_EN is defined.
REQ-008 SHALL have port digits  output  8  display value, [7:4] tens BCD, [3:0] ones BCD.
REQ-009 SHALL have port run_state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE; 11 never driven.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse on count wrap to 00.

Function
REQ-011 SHALL register tick_in into tick_prev every cycle; tick event = tick_in & ~tick_prev (rising edge only).
REQ-012 SHALL count one tick event per rising edge of tick_in; the count register SHALL update on the same clk edge that samples the event (digits change 1 cycle after tick_in rises).
REQ-013 SHALL increment ones 0..9; ones 9 + event -> ones 0, tens +1.
REQ-014 SHALL, at tens=TENS_MAX and ones=9 with an event, load 00 and assert wrap for exactly that one cycle.
REQ-015 SHALL hold ones and tens at valid BCD at all times; codes A..F SHALL never appear.
REQ-016 SHALL implement FSM transitions: IDLE+start_stop->RUN; RUN+start_stop->PAUSE; PAUSE+start_stop->RUN; no other input changes state, except clear.
REQ-017 SHALL count tick events only while the current (pre-edge) state is RUN; events in IDLE or PAUSE are discarded, not deferred.
REQ-018 SHALL, on tick event coincident with start_stop in RUN, count the event and enter PAUSE.
REQ-019 SHALL, on clear in any state, load count 00, enter IDLE, deassert wrap; clear SHALL override start_stop and a coincident tick event.
REQ-020 SHALL hold count unchanged in PAUSE; PAUSE->RUN resumes from the held value.
REQ-021 SHALL ignore start_stop held high for multiple cycles no differently than repeated pulses (each high cycle is one request); debouncing is upstream.

Reset
REQ-022 SHALL, on reset low, immediately force run_state=00, digits=8'h00, wrap=0, tick_prev=0, lap hold cleared, independent of clk.
REQ-023 SHALL resume normal operation on the first rising clk edge after reset deasserts; a tick_in already high at that edge SHALL be seen as an event but is discarded because state is IDLE.
REQ-024 SHALL, on reset asserted mid-RUN, discard the count; no wrap pulse SHALL be produced by reset.

Configuration
REQ-025 SHALL compile a lap-freeze feature when macro STOPWATCH_LAP_EN is defined: lap pulse in RUN or PAUSE toggles a freeze flag; on freeze set, digits latches the current count and holds it while the internal count keeps running; on freeze clear, digits tracks the live count again next cycle; clear or reset clears the freeze flag.
REQ-026 SHALL, without STOPWATCH_LAP_EN, ignore lap entirely, and digits SHALL always equal the live count.

Verification
REQ-027 SHALL cover: reset low, tick_in toggling every 6 clk -> digits=00, run_state=00, no wrap for 100 cycles.
REQ-028 SHALL cover: start_stop pulse, then 12 tick_in rising edges -> run_state=01, digits=8'h12, each increment 1 cycle after edge.
REQ-029 SHALL cover: TENS_MAX=5, run 60 edges from 00 -> digits 59 then 00, wrap high exactly one cycle, coincident with 00.
REQ-030 SHALL cover: at 8'h23 start_stop, 5 edges, start_stop, 2 edges -> PAUSE holds 23, final digits=8'h25.
REQ-031 SHALL cover: clear and start_stop and tick edge in same cycle while RUN at 8'h41 -> digits=00, run_state=00, wrap=0.
REQ-032 SHALL cover (STOPWATCH_LAP_EN): at 8'h07 lap, 10 edges, lap -> digits 07 during freeze, then 8'h17 one cycle after second lap.
